// File: rtl/dmem_port_arbiter_pkg.sv
// Shared types and constants for the data-memory port arbiter.
package dmem_port_arbiter_pkg;

    // Owner encoding used by the round-robin pointer and the response tags.
    localparam logic OWN_IF = 1'b0;
    localparam logic OWN_LS = 1'b1;

    // Supported read-latency window of the external synchronous RAM.
    localparam int RD_LAT_MIN = 1;
    localparam int RD_LAT_MAX = 4;

    // One in-flight access: who issued it and whether it was a store.
    typedef struct packed {
        logic valid;
        logic owner;
        logic is_store;
    } rsp_tag_t;

    // True when the requested read latency is one the tag pipe supports.
    function automatic bit rd_latency_ok(input int lat);
        return (lat >= RD_LAT_MIN) && (lat <= RD_LAT_MAX);
    endfunction

endpackage

// File: rtl/dmem_port_arbiter_if.sv
// Bundle of the fetch port, load/store port and external memory bus.
// Handshake: a requester raises *_req with a stable payload and keeps both
// unchanged until it sees *_gnt high; the transfer happens in the cycle
// where req and gnt are both 1. Responses are one-cycle *_rvalid pulses.
interface dmem_port_arbiter_if #(
    parameter int AW = 32
);
    // Fetch requester
    logic          i_if_req;
    logic [AW-1:0] i_if_addr;
    logic          o_if_gnt;
    logic          o_if_rvalid;
    logic [31:0]   o_if_rdata;

    // Load/store requester
    logic          i_ls_req;
    logic          i_ls_wen;
    logic [AW-1:0] i_ls_addr;
    logic [3:0]    i_ls_mask;
    logic [31:0]   i_ls_wdata;
    logic          o_ls_gnt;
    logic          o_ls_rvalid;
    logic [31:0]   o_ls_rdata;

    // External memory
    logic [AW-1:0] o_dmem_addr;
    logic [3:0]    o_dmem_mask;
    logic [31:0]   o_dmem_wdata;
    logic          o_dmem_ren;
    logic          o_dmem_wen;
    logic [31:0]   i_dmem_rdata;

    // Arbiter side
    modport slave (
        input  i_if_req, i_if_addr,
        output o_if_gnt, o_if_rvalid, o_if_rdata,
        input  i_ls_req, i_ls_wen, i_ls_addr, i_ls_mask, i_ls_wdata,
        output o_ls_gnt, o_ls_rvalid, o_ls_rdata,
        output o_dmem_addr, o_dmem_mask, o_dmem_wdata, o_dmem_ren, o_dmem_wen,
        input  i_dmem_rdata
    );

    // Requesters and memory side
    modport master (
        output i_if_req, i_if_addr,
        input  o_if_gnt, o_if_rvalid, o_if_rdata,
        output i_ls_req, i_ls_wen, i_ls_addr, i_ls_mask, i_ls_wdata,
        input  o_ls_gnt, o_ls_rvalid, o_ls_rdata,
        input  o_dmem_addr, o_dmem_mask, o_dmem_wdata, o_dmem_ren, o_dmem_wen,
        output i_dmem_rdata
    );
endinterface

// File: rtl/dmem_port_arbiter_rsp_tag_pipe.sv
// Fixed-depth shift register of response tags; the tail lines up with the
// cycle in which the memory presents read data for that access.
module rsp_tag_pipe
    import dmem_port_arbiter_pkg::*;
#(
    parameter int DEPTH = 1
) (
    input  logic     i_clk,
    input  logic     i_rst,
    input  rsp_tag_t i_tag,
    output rsp_tag_t o_tag
);

    rsp_tag_t stage_q [DEPTH];
    rsp_tag_t stage_d [DEPTH];

    // Next state: new tag enters at the head, everything else moves one step.
    always_comb begin
        stage_d[0] = i_tag;
        for (int i = 1; i < DEPTH; i++) begin
            stage_d[i] = stage_q[i-1];
        end
    end

    // Synchronous clear drops every in-flight tag.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                stage_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                stage_q[i] <= stage_d[i];
            end
        end
    end

    assign o_tag = stage_q[DEPTH-1];

endmodule

// File: rtl/dmem_port_arbiter.sv
// Round-robin sharing of one data-memory port between instruction fetch and
// the load/store stage, with responses routed back by issue-order tags.
module dmem_port_arbiter
    import dmem_port_arbiter_pkg::*;
#(
    parameter int RD_LATENCY = 1,
    parameter int AW         = 32
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    dmem_port_arbiter_if.slave   bus
);

    if (!rd_latency_ok(RD_LATENCY)) begin : g_bad_latency
        $error("dmem_port_arbiter: RD_LATENCY must be in 1..4");
    end

    logic     last_owner_q;
    logic     last_owner_d;
    logic     if_gnt;
    logic     ls_gnt;
    rsp_tag_t push_tag;
    rsp_tag_t tail_tag;

    logic [AW-1:0] dmem_addr;
    logic [3:0]    dmem_mask;
    logic [31:0]   dmem_wdata;
    logic          dmem_ren;
    logic          dmem_wen;

    // Grant selection: a lone requester always wins; on contention the one
    // that did not own the port last time wins. Nothing is granted in reset.
    always_comb begin
        if_gnt = 1'b0;
        ls_gnt = 1'b0;
        if (!i_rst) begin
            if (bus.i_if_req && bus.i_ls_req) begin
                if (last_owner_q == OWN_IF) begin
                    ls_gnt = 1'b1;
                end else begin
                    if_gnt = 1'b1;
                end
            end else begin
                if_gnt = bus.i_if_req;
                ls_gnt = bus.i_ls_req;
            end
        end
    end

    // Round-robin pointer follows every grant and holds otherwise.
    always_comb begin
        last_owner_d = last_owner_q;
        if (if_gnt) begin
            last_owner_d = OWN_IF;
        end else if (ls_gnt) begin
            last_owner_d = OWN_LS;
        end
    end

    // Reset to IF so the first contended cycle goes to LS.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            last_owner_q <= OWN_IF;
        end else begin
            last_owner_q <= last_owner_d;
        end
    end

    // Memory bus mux: fetches are full-word reads; idle bus is all zeros.
    always_comb begin
        dmem_addr  = '0;
        dmem_mask  = '0;
        dmem_wdata = '0;
        dmem_ren   = 1'b0;
        dmem_wen   = 1'b0;
        if (if_gnt) begin
            dmem_addr = bus.i_if_addr;
            dmem_mask = 4'hF;
            dmem_ren  = 1'b1;
        end else if (ls_gnt) begin
            dmem_addr  = bus.i_ls_addr;
            dmem_mask  = bus.i_ls_mask;
            dmem_wdata = bus.i_ls_wdata;
            dmem_ren   = ~bus.i_ls_wen;
            dmem_wen   = bus.i_ls_wen;
        end
    end

    // Tag describing the access issued this cycle (or an empty slot).
    always_comb begin
        push_tag          = '0;
        push_tag.valid    = if_gnt | ls_gnt;
        push_tag.owner    = ls_gnt ? OWN_LS : OWN_IF;
        push_tag.is_store = ls_gnt & bus.i_ls_wen;
    end

    rsp_tag_pipe #(
        .DEPTH (RD_LATENCY)
    ) u_tag_pipe (
        .i_clk (i_clk),
        .i_rst (i_rst),
        .i_tag (push_tag),
        .o_tag (tail_tag)
    );

    assign bus.o_if_gnt     = if_gnt;
    assign bus.o_ls_gnt     = ls_gnt;
    assign bus.o_dmem_addr  = dmem_addr;
    assign bus.o_dmem_mask  = dmem_mask;
    assign bus.o_dmem_wdata = dmem_wdata;
    assign bus.o_dmem_ren   = dmem_ren;
    assign bus.o_dmem_wen   = dmem_wen;

    // Response routing: only the owner of the emerging tag sees rvalid/data;
    // stores answer with zero data. Suppressed while reset is held.
    always_comb begin
        bus.o_if_rvalid = 1'b0;
        bus.o_if_rdata  = '0;
        bus.o_ls_rvalid = 1'b0;
        bus.o_ls_rdata  = '0;
        if (!i_rst && tail_tag.valid) begin
            if (tail_tag.owner == OWN_IF) begin
                bus.o_if_rvalid = 1'b1;
                bus.o_if_rdata  = bus.i_dmem_rdata;
            end else begin
                bus.o_ls_rvalid = 1'b1;
                bus.o_ls_rdata  = tail_tag.is_store ? 32'h0 : bus.i_dmem_rdata;
            end
        end
    end

endmodule
